// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher round scheduler: one round per clk, shared inverse S-box bank, async key store.
// Optional build macro AES_INV_ABORT_EN adds an abort input that drops the block in flight.

module aes_inv_mix_columns (
  input  logic [0:127] din,
  output logic [0:127] dout
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] imc_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign dout[32*c +: 32] = imc_col(din[32*c +: 32]);
  end
endmodule

module aes_inv_cipher_ctrl #(
  parameter int NR     = 10,
  parameter int KEY_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:127]      din,
  output logic [KEY_AW-1:0] key_addr,
  input  logic [0:127]      key_data,
  output logic              sbox_req,
  output logic [0:127]      sbox_in,
  input  logic [0:127]      sbox_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:127]      dout,
  output logic              busy
`ifdef AES_INV_ABORT_EN
  ,
  input  logic              abort
`endif
);
  // state | meaning
  // IDLE  | waiting for ciphertext
  // INIT  | initial AddRoundKey with key NR
  // ROUND | full inverse rounds, rnd = NR-1 .. 1
  // FINAL | last round without InvMixColumns, key 0
  // DONE  | plaintext held on dout until out_ready
  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;

  localparam logic [KEY_AW-1:0] NR_K  = KEY_AW'(NR);
  localparam logic [KEY_AW-1:0] NR_M1 = KEY_AW'(NR - 1);

  state_t              state;
  logic [0:127]        state_reg;
  logic [KEY_AW-1:0]   rnd;
  logic [0:127]        imc_out;
  logic                accept;
  logic                abort_i;

`ifdef AES_INV_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign dout     = state_reg;

  // InvShiftRows: row r of column c takes row r of column (c - r) mod 4
  always_comb begin
    sbox_in = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sbox_in[8*(4*c+r) +: 8] = state_reg[8*(4*((c-r+4)%4)+r) +: 8];
  end

  aes_inv_mix_columns u_imc (
    .din  (sbox_out ^ key_data),
    .dout (imc_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      state_reg <= '0;
      rnd       <= '0;
      key_addr  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sbox_req  <= 1'b0;
    end else if (abort_i && state != IDLE) begin
      state     <= IDLE;
      state_reg <= '0;
      rnd       <= '0;
      key_addr  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sbox_req  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_reg <= din;
            key_addr  <= NR_K;
            rnd       <= NR_M1;
            busy      <= 1'b1;
            state     <= INIT;
          end
        end
        INIT: begin
          state_reg <= state_reg ^ key_data;
          key_addr  <= NR_M1;
          sbox_req  <= 1'b1;
          state     <= ROUND;
        end
        ROUND: begin
          state_reg <= imc_out;
          key_addr  <= rnd - 1'b1;
          rnd       <= rnd - 1'b1;
          if (rnd == KEY_AW'(1)) state <= FINAL;
        end
        FINAL: begin
          state_reg <= sbox_out ^ key_data;
          sbox_req  <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              // back-to-back: next block starts without passing through IDLE
              state_reg <= din;
              key_addr  <= NR_K;
              rnd       <= NR_M1;
              state     <= INIT;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Self-checking bench for aes_inv_cipher_ctrl: FIPS-197 reference model, S-box bank and key store.
// Build with AES_INV_ABORT_EN defined to also exercise the abort path.
module tb_aes_inv_cipher_ctrl;
  localparam int NR     = 10;
  localparam int KEY_AW = 4;
  localparam logic [0:127] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, abort = 1'b0;
  logic in_ready, sbox_req, out_valid, busy;
  logic [0:127] din = '0;
  logic [0:127] key_data, sbox_in, sbox_out, dout;
  logic [KEY_AW-1:0] key_addr;

  logic [7:0]   sb_f [256];
  logic [7:0]   sb_i [256];
  logic [0:127] rk   [16];
  int checks = 0, errors = 0, cyc = 0, hs_cnt = 0;
  int rise_cyc [$];
  logic ov_prev = 1'b0;

  always #5 clk = ~clk;

  aes_inv_cipher_ctrl #(.NR(NR), .KEY_AW(KEY_AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .key_addr(key_addr), .key_data(key_data), .sbox_req(sbox_req), .sbox_in(sbox_in),
    .sbox_out(sbox_out), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .busy(busy)
`ifdef AES_INV_ABORT_EN
    , .abort(abort)
`endif
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [0:127] isr(input logic [0:127] s);
    logic [0:127] o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = s[8*((((k/4) - (k%4) + 4) % 4)*4 + (k%4)) +: 8];
    return o;
  endfunction

  function automatic logic [0:127] isb(input logic [0:127] s);
    logic [0:127] o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = sb_i[s[8*k +: 8]];
    return o;
  endfunction

  function automatic logic [0:127] imc(input logic [0:127] s);
    logic [7:0] coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [0:127] o;
    logic [7:0] acc;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - i + 4) % 4], s[8*(4*c+j) +: 8]);
        o[8*(4*c+i) +: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [0:127] ref_decrypt(input logic [0:127] ct);
    logic [0:127] s = ct ^ rk[NR];
    for (int r = NR - 1; r >= 1; r--) s = imc(isb(isr(s)) ^ rk[r]);
    return isb(isr(s)) ^ rk[0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, rc;
    logic [31:0] w [44];
    logic [31:0] t;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_f[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) sb_i[sb_f[x]] = 8'(x);
    for (int i = 0; i < 4; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_f[t[31:24]], sb_f[t[23:16]], sb_f[t[15:8]], sb_f[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  assign key_data = rk[key_addr];
  always_comb sbox_out = isb(sbox_in);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Timeline model: t counts edges since the accept edge of the block in flight
  int m_st = 0, m_t = 0, m_kaddr = 0;
  logic m_valid = 1'b0, m_zero = 1'b1;
  logic [0:127] m_exp = '0;
  logic m_abort, m_ready, m_acc, m_req;
  assign m_abort = abort && (m_st != 0);
  assign m_ready = (m_st == 0) || (m_st == 2 && out_ready);
  assign m_acc   = in_valid && m_ready && !m_abort;
  assign m_req   = (m_st == 1) && (m_t >= 1) && (m_t <= NR);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || m_abort) begin
      m_st <= 0; m_valid <= 1'b0; m_kaddr <= 0; m_zero <= 1'b1;
    end else if (m_acc) begin
      m_st <= 1; m_t <= 0; m_valid <= 1'b0; m_kaddr <= NR; m_zero <= 1'b0;
      m_exp <= ref_decrypt(din);
    end else if (m_st == 1) begin
      m_t <= m_t + 1;
      if (m_t + 1 <= NR) m_kaddr <= NR - (m_t + 1);
      if (m_t + 1 == NR + 1) begin m_st <= 2; m_valid <= 1'b1; end
    end else if (m_st == 2 && out_ready) begin
      m_st <= 0; m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, m_ready);
    chk("out_valid", out_valid, m_valid);
    chk("busy", busy, m_st != 0);
    chk("key_addr", key_addr, m_kaddr[KEY_AW-1:0]);
    chk("sbox_req", sbox_req, m_req);
    if (m_req) chk("sbox_in", sbox_in, isr(dout));
    if (m_valid) chk("dout", dout, m_exp);
    if (m_zero) chk("dout_zero", dout, '0);
    if (out_valid && !ov_prev) rise_cyc.push_back(cyc);
    ov_prev <= out_valid;
    if (out_valid && out_ready && !m_abort) hs_cnt <= hs_cnt + 1;
  end

  task automatic send(input logic [0:127] ct, input bit keep);
    int k = 0;
    din = ct; in_valid = 1'b1;
    while (!in_ready && k < 100) begin @(posedge clk); #2; k++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #2;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #2; n++; end
    if (!out_valid) chk("valid_timeout", 0, 1);
  endtask

  initial begin
    int n, r0;
    logic [0:127] pats [3] = '{128'h0, {128{1'b1}}, 128'h0123456789abcdeffedcba9876543210};
    build_tables();
    chk("rk10_literal", rk[10], C1_RK10);
    chk("model_c1_literal", ref_decrypt(C1_CT), C1_PT);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_dout", dout, '0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_key_addr", key_addr, 0);

    // FIPS-197 C.1 single block and latency
    out_ready = 1'b1;
    send(C1_CT, 1'b0);
    wait_valid(n);
    chk("c1_latency", n, NR + 1);
    chk("c1_dout", dout, C1_PT);
    @(posedge clk); #2;

    // back-pressure
    out_ready = 1'b0;
    send(C1_CT, 1'b0);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      chk("bp_dout", dout, C1_PT);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_busy", busy, 0);

    // back-to-back with in_valid held high
    r0 = rise_cyc.size();
    send(C1_CT, 1'b1);
    wait_valid(n);
    chk("b2b_lat1", n, NR + 1);
    chk("b2b_dout1", dout, C1_PT);
    @(posedge clk); #2;
    in_valid = 1'b0;
    chk("b2b_second_accept", busy, 1);
    wait_valid(n);
    chk("b2b_lat2", n, NR + 1);
    chk("b2b_dout2", dout, C1_PT);
    @(posedge clk); #2;
    if (rise_cyc.size() >= r0 + 2) chk("b2b_spacing", rise_cyc[r0+1] - rise_cyc[r0], NR + 2);
    else chk("b2b_rises", rise_cyc.size() - r0, 2);

    // further ciphertext patterns checked against the model
    foreach (pats[i]) begin
      send(pats[i], 1'b0);
      wait_valid(n);
      @(posedge clk); #2;
    end

    // reset in ROUND with rnd = 5
    send(C1_CT, 1'b0);
    repeat (5) begin @(posedge clk); #2; end
    chk("mid_key_addr", key_addr, 5);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_dout", dout, '0);
    chk("mid_rst_busy", busy, 0);
    send(C1_CT, 1'b0);
    wait_valid(n);
    chk("post_rst_dout", dout, C1_PT);
    @(posedge clk); #2;

`ifdef AES_INV_ABORT_EN
    r0 = rise_cyc.size();
    send(C1_CT, 1'b0);
    repeat (7) begin @(posedge clk); #2; end
    chk("ab_key_addr", key_addr, 3);
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    chk("ab_valid", out_valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_dout", dout, '0);
    repeat (15) begin @(posedge clk); #2; end
    chk("ab_no_output", rise_cyc.size(), r0);
    out_ready = 1'b0;
    send(C1_CT, 1'b0);
    wait_valid(n);
    abort = 1'b1; in_valid = 1'b1; out_ready = 1'b1; din = pats[2];
    @(posedge clk); #2;
    abort = 1'b0; in_valid = 1'b0;
    chk("ab_done_busy", busy, 0);
    chk("ab_done_valid", out_valid, 0);
    chk("ab_done_in_ready", in_ready, 1);
    repeat (3) begin @(posedge clk); #2; end
`endif

    chk("handshakes", hs_cnt, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/aes_inv_cipher_ctrl.md
Name: aes_inv_cipher_ctrl

Overview:
- Iterative AES inverse-cipher round scheduler; one round per clock.
- Owns the 128-bit state register and applies InvShiftRows (inline wiring) and AddRoundKey.
- Instantiates the team's inverse MixColumns block; InvSubBytes comes from an external shared inverse S-box bank over a request/return port.
- Reads round keys from an external key store (async read) and delivers plaintext with a valid/ready handshake.

Parameters:
- NR, 10, number of rounds; legal values 10/12/14 (AES-128/192/256).
- KEY_AW, 4, key-store address width; must satisfy 2^KEY_AW > NR.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ciphertext valid
- in_ready  out  1  ciphertext accepted when in_valid & in_ready
- din  in  [0:127]  ciphertext; byte k = din[8k:8k+7], column-major (bytes 0-3 = column 0)
- key_addr  out  KEY_AW  round-key index (registered)
- key_data  in  [0:127]  round key for key_addr, combinational same cycle
- sbox_req  out  1  high when sbox_in is meaningful
- sbox_in  out  [0:127]  InvShiftRows(state_reg)
- sbox_out  in  [0:127]  InvSubBytes(sbox_in), combinational same cycle
- out_valid  out  1  plaintext valid
- out_ready  in  1  consumer accepts
- dout  out  [0:127]  plaintext (state_reg)
- busy  out  1  FSM not IDLE

Behaviour:
- Reset values: state IDLE, state_reg 0, rnd 0, key_addr 0, out_valid 0, busy 0, sbox_req 0. Reset wins over every other event.
- FSM states: IDLE, INIT, ROUND, FINAL, DONE.
- in_ready = (IDLE) | (DONE & out_ready).
- IDLE: on accept:
  - state_reg <= din; key_addr <= NR; rnd <= NR-1; go to INIT.
- INIT (1 cycle):
  - state_reg <= state_reg ^ key_data; key_addr <= NR-1; go to ROUND.
- ROUND (NR-1 cycles, rnd = NR-1 down to 1):
  - sbox_req = 1.
  - state_reg <= InvMixColumns(sbox_out ^ key_data); key_addr <= rnd-1; rnd <= rnd-1.
  - When rnd == 1, go to FINAL.
- FINAL (1 cycle):
  - sbox_req = 1; state_reg <= sbox_out ^ key_data (key 0; no InvMixColumns); go to DONE.
- DONE:
  - out_valid = 1; dout holds until out_ready.
  - out_ready with no new in_valid: go to IDLE.
  - out_ready with in_valid: back-to-back accept; go directly to INIT, loading din/key_addr as in IDLE.
- InvShiftRows: row r (byte index mod 4 = r) rotates right by r columns. Output byte (c,r) = input byte ((c-r) mod 4, r).
- Latency: out_valid rises NR+1 edges after the accept edge (11 for NR=10). Throughput with out_ready held high: one block per NR+2 cycles.
- in_valid outside IDLE/DONE is ignored; din is sampled only on accept.
- dout is not cleared on handshake; it is only meaningful while out_valid = 1.
- sbox_in is driven continuously; consumers qualify it with sbox_req.

Optional Feature:
- Macro: AES_INV_ABORT_EN.
- Defined:
  - Adds input `abort` (1 bit).
  - abort high in INIT/ROUND/FINAL/DONE forces IDLE next edge; state_reg cleared to 0, out_valid 0, no output produced.
  - abort in IDLE has no effect; abort has priority over accept in DONE.
- Undefined: no abort port; each accepted block always completes.

Test Plan:
- FIPS-197 C.1 (NR=10): din 69c4e0d86a7b0430d8cdb78070b4c55a, key store holding expansion of 000102030405060708090a0b0c0d0e0f (rk10 = 13111d7fe3944a17f307a78b4d2b30c5) -> dout 00112233445566778899aabbccddeeff, out_valid exactly 11 edges after accept, key_addr sequence 10,9,...,0.
- Back-pressure: out_ready low 5 cycles after out_valid -> dout and out_valid stable; in_ready 0 throughout; one handshake on release.
- Back-to-back: two C.1 blocks with out_ready=1 and in_valid continuously high -> second accept in DONE cycle of first; outputs 12 cycles apart, both correct.
- Reset mid-op: assert rst during ROUND rnd=5 -> next edge IDLE, out_valid 0, state_reg 0; a fresh block afterwards decrypts correctly.
- S-box port: check sbox_req high for exactly NR cycles per block and sbox_in == InvShiftRows(state_reg) each of those cycles.
- AES_INV_ABORT_EN: abort at ROUND rnd=3 -> IDLE next edge, no out_valid; abort plus in_valid in DONE -> no accept.
